// File: rtl/axi_to_stream_b_fifo.sv
// AXI4 write-response snooper: passes B responses straight through and queues a copy
// of each as a single-beat packet on the shared stream output.
module axi_to_stream_b_fifo #(
    parameter int                           DATA_WIDTH        = 128,
    parameter int                           ID_WIDTH          = 32,
    parameter int                           USER_WIDTH        = 64,
    parameter int                           STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b000,
    parameter int                           FIFO_DEPTH        = 4,
    parameter int                           INCLUDE_USER      = 0,
    parameter int                           BLOCK_ON_FULL     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ready,
    output logic                            valid,
    output logic                            in_progress,
    output logic                            last,
    output logic [DATA_WIDTH-1:0]           data,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy,
    output logic [15:0]                     drop_count,
    input  logic [ID_WIDTH-1:0]             AXIS_bid,
    input  logic [1:0]                      AXIS_bresp,
    input  logic [USER_WIDTH-1:0]           AXIS_buser,
    input  logic                            AXIS_bvalid,
    output logic                            AXIS_bready,
    output logic [ID_WIDTH-1:0]             AXIM_bid,
    output logic [1:0]                      AXIM_bresp,
    output logic [USER_WIDTH-1:0]           AXIM_buser,
    output logic                            AXIM_bvalid,
    input  logic                            AXIM_bready
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = PTR_W + 1;
    localparam int USER_BITS  = (INCLUDE_USER != 0) ? USER_WIDTH : 0;
    localparam int MIN_DATA_W = STREAM_TYPE_WIDTH + ID_WIDTH + 2 + USER_BITS;
    localparam int TYPE_LSB   = DATA_WIDTH - STREAM_TYPE_WIDTH;
    localparam int ID_LSB     = DATA_WIDTH - STREAM_TYPE_WIDTH - ID_WIDTH;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    if (DATA_WIDTH < MIN_DATA_W) begin : g_width_check
        $error("axi_to_stream_b_fifo: DATA_WIDTH %0d too narrow, need %0d", DATA_WIDTH, MIN_DATA_W);
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("axi_to_stream_b_fifo: FIFO_DEPTH %0d must be a power of two >= 2", FIFO_DEPTH);
    end

    logic [ID_WIDTH-1:0]   id_mem_r   [FIFO_DEPTH];
    logic [1:0]            resp_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      occ_r;
    logic [15:0]           drop_cnt_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  gate_s;
    logic                  cap_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] user_part_s;
    logic [DATA_WIDTH-1:0] beat_s;

    // Gating, capture/drop and pop decisions; full/empty come only from registered occupancy
    always_comb begin
        full_s  = (occ_r == OCC_FULL);
        empty_s = (occ_r == {OCC_W{1'b0}});
        gate_s  = reset || !((BLOCK_ON_FULL != 0) && full_s);
        cap_s   = !reset && AXIS_bvalid && AXIM_bready && gate_s;
        push_s  = cap_s && !full_s;
        drop_s  = cap_s && full_s;
        pop_s   = !empty_s && ready;
    end

    assign AXIM_bid    = AXIS_bid;
    assign AXIM_bresp  = AXIS_bresp;
    assign AXIM_buser  = AXIS_buser;
    assign AXIM_bvalid = AXIS_bvalid && gate_s;
    assign AXIS_bready = AXIM_bready && gate_s;

    assign valid       = !empty_s;
    assign in_progress = pop_s;
    assign last        = pop_s;
    assign occupancy   = occ_r;
    assign drop_count  = drop_cnt_r;
    assign data        = beat_s;

    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {OCC_W{1'b0}};
            drop_cnt_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    // Response storage; entries need no reset since occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_r[wr_ptr_r]   <= AXIS_bid;
            resp_mem_r[wr_ptr_r] <= AXIS_bresp;
        end
    end

    if (INCLUDE_USER != 0) begin : g_user
        logic [USER_WIDTH-1:0] user_mem_r [FIFO_DEPTH];

        // buser storage, present only when it is packed into the beat
        always_ff @(posedge clk) begin
            if (push_s) begin
                user_mem_r[wr_ptr_r] <= AXIS_buser;
            end
        end

        assign user_part_s = DATA_WIDTH'(user_mem_r[rd_ptr_r]) << 2;
    end else begin : g_no_user
        assign user_part_s = {DATA_WIDTH{1'b0}};
    end

    // Beat layout from the FIFO head: type | id | zero pad | (user) | resp
    always_comb begin
        beat_s                                  = {DATA_WIDTH{1'b0}};
        beat_s[TYPE_LSB +: STREAM_TYPE_WIDTH]   = STREAM_TYPE;
        beat_s[ID_LSB +: ID_WIDTH]              = id_mem_r[rd_ptr_r];
        beat_s[1:0]                             = resp_mem_r[rd_ptr_r];
        beat_s                                  = beat_s | user_part_s;
    end

endmodule

// File: tb/tb_axi_to_stream_b_fifo.sv
// Directed bench: one blocking instance, one dropping instance and one user-packing
// instance share the same AXI/stream stimulus; each check targets the relevant instance.
module tb_axi_to_stream_b_fifo;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic [31:0]  bid;
    logic [1:0]   bresp;
    logic [63:0]  buser;
    logic         bvalid;
    logic         m_bready;

    logic         blk_valid, blk_inprog, blk_last, blk_s_bready, blk_m_bvalid;
    logic [127:0] blk_data;
    logic [2:0]   blk_occ;
    logic [15:0]  blk_drops;
    logic [31:0]  blk_m_bid;
    logic [1:0]   blk_m_bresp;
    logic [63:0]  blk_m_buser;

    logic         drp_valid, drp_inprog, drp_last, drp_s_bready, drp_m_bvalid;
    logic [127:0] drp_data;
    logic [2:0]   drp_occ;
    logic [15:0]  drp_drops;
    logic [31:0]  drp_m_bid;
    logic [1:0]   drp_m_bresp;
    logic [63:0]  drp_m_buser;

    logic         usr_valid, usr_inprog, usr_last, usr_s_bready, usr_m_bvalid;
    logic [127:0] usr_data;
    logic [2:0]   usr_occ;
    logic [15:0]  usr_drops;
    logic [31:0]  usr_m_bid;
    logic [1:0]   usr_m_bresp;
    logic [63:0]  usr_m_buser;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] BEAT_ID5  = (128'h5 << 93) | 128'h2;
    localparam logic [127:0] BEAT_USER = (128'h5 << 125) | (128'hA << 93)
                                       | (128'hDEAD_BEEF_0000_0001 << 2) | 128'h1;

    always #5 clk = ~clk;

    axi_to_stream_b_fifo #(.BLOCK_ON_FULL(1)) u_blk (
        .clk(clk), .reset(reset), .ready(ready), .valid(blk_valid), .in_progress(blk_inprog),
        .last(blk_last), .data(blk_data), .occupancy(blk_occ), .drop_count(blk_drops),
        .AXIS_bid(bid), .AXIS_bresp(bresp), .AXIS_buser(buser), .AXIS_bvalid(bvalid),
        .AXIS_bready(blk_s_bready), .AXIM_bid(blk_m_bid), .AXIM_bresp(blk_m_bresp),
        .AXIM_buser(blk_m_buser), .AXIM_bvalid(blk_m_bvalid), .AXIM_bready(m_bready)
    );

    axi_to_stream_b_fifo #(.BLOCK_ON_FULL(0)) u_drp (
        .clk(clk), .reset(reset), .ready(ready), .valid(drp_valid), .in_progress(drp_inprog),
        .last(drp_last), .data(drp_data), .occupancy(drp_occ), .drop_count(drp_drops),
        .AXIS_bid(bid), .AXIS_bresp(bresp), .AXIS_buser(buser), .AXIS_bvalid(bvalid),
        .AXIS_bready(drp_s_bready), .AXIM_bid(drp_m_bid), .AXIM_bresp(drp_m_bresp),
        .AXIM_buser(drp_m_buser), .AXIM_bvalid(drp_m_bvalid), .AXIM_bready(m_bready)
    );

    axi_to_stream_b_fifo #(.BLOCK_ON_FULL(1), .INCLUDE_USER(1), .STREAM_TYPE(3'b101)) u_usr (
        .clk(clk), .reset(reset), .ready(ready), .valid(usr_valid), .in_progress(usr_inprog),
        .last(usr_last), .data(usr_data), .occupancy(usr_occ), .drop_count(usr_drops),
        .AXIS_bid(bid), .AXIS_bresp(bresp), .AXIS_buser(buser), .AXIS_bvalid(bvalid),
        .AXIS_bready(usr_s_bready), .AXIM_bid(usr_m_bid), .AXIM_bresp(usr_m_bresp),
        .AXIM_buser(usr_m_buser), .AXIM_bvalid(usr_m_bvalid), .AXIM_bready(m_bready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        reset = 1'b1; ready = 1'b0; bid = 32'h7; bresp = 2'b11;
        buser = 64'h1234; bvalid = 1'b1; m_bready = 1'b1;

        // Reset held two cycles with a live handshake: ungated, nothing captured
        cyc(); cyc();
        chk("rst_s_bready",  blk_s_bready, 1'b1);
        chk("rst_m_bvalid",  blk_m_bvalid, 1'b1);
        chk("rst_m_bid",     blk_m_bid, 32'h7);
        chk("rst_m_bresp",   drp_m_bresp, 2'b11);
        chk("rst_m_buser",   usr_m_buser, 64'h1234);
        chk("rst_valid",     blk_valid, 1'b0);
        chk("rst_occ",       blk_occ, 3'd0);
        chk("rst_drops",     drp_drops, 16'd0);
        chk("rst_usr_occ",   usr_occ, 3'd0);

        // Single response, one-cycle latency to the stream
        reset = 1'b0; bid = 32'h5; bresp = 2'b10; buser = 64'h0; ready = 1'b1;
        cyc();
        bvalid = 1'b0;
        #1;
        chk("single_valid",  blk_valid, 1'b1);
        chk("single_data",   blk_data, BEAT_ID5);
        chk("single_drp",    drp_data, BEAT_ID5);
        chk("single_last",   blk_last, 1'b1);
        chk("single_inprog", drp_inprog, 1'b1);
        chk("single_ulast",  usr_last, 1'b1);
        cyc();
        chk("single_done_v", blk_valid, 1'b0);
        chk("single_done_l", blk_last, 1'b0);
        chk("single_done_i", usr_inprog, 1'b0);

        // Back-pressure: four captured, the fifth gated
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bid = i; bvalid = 1'b1;
            #1;
            chk("bp_accept", blk_s_bready, 1'b1);
            cyc();
        end
        bid = 32'h4;
        #1;
        chk("bp_gated_rdy",  blk_s_bready, 1'b0);
        chk("bp_gated_val",  blk_m_bvalid, 1'b0);
        chk("bp_full_occ",   blk_occ, 3'd4);
        cyc();
        chk("bp_still_gate", blk_s_bready, 1'b0);
        ready = 1'b1;
        #1;
        chk("bp_pop_gate",   blk_s_bready, 1'b0);
        chk("bp_head0",      blk_data[124:93], 32'h0);
        cyc();
        chk("bp_head1",      blk_data[124:93], 32'h1);
        chk("bp_reopen",     blk_s_bready, 1'b1);
        chk("bp_occ3",       blk_occ, 3'd3);
        cyc();
        bid = 32'h5;
        #1;
        chk("bp_head2",      blk_data[124:93], 32'h2);
        chk("bp_accept5",    blk_s_bready, 1'b1);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("bp_head3",      blk_data[124:93], 32'h3);
        chk("bp_occ3b",      blk_occ, 3'd3);
        cyc();
        chk("bp_head4",      blk_data[124:93], 32'h4);
        cyc();
        chk("bp_head5",      blk_data[124:93], 32'h5);
        chk("bp_occ1",       blk_occ, 3'd1);
        cyc();
        chk("bp_empty",      blk_valid, 1'b0);

        // Drop mode: all six handshakes complete, two copies dropped
        reset = 1'b1; ready = 1'b0; bvalid = 1'b0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bid = i; bvalid = 1'b1;
            #1;
            chk("drop_accept", drp_s_bready, 1'b1);
            cyc();
        end
        bvalid = 1'b0;
        #1;
        chk("drop_occ",      drp_occ, 3'd4);
        chk("drop_count",    drp_drops, 16'd2);

        // Full with simultaneous pop: same-cycle pop does not free a slot
        ready = 1'b1; bid = 32'h9; bvalid = 1'b1;
        #1;
        chk("fp_drp_rdy",    drp_s_bready, 1'b1);
        chk("fp_drp_mval",   drp_m_bvalid, 1'b1);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("fp_drop3",      drp_drops, 16'd3);
        chk("fp_occ3",       drp_occ, 3'd3);
        chk("fp_head1",      drp_data[124:93], 32'h1);
        cyc();
        chk("fp_head2",      drp_data[124:93], 32'h2);
        cyc();
        chk("fp_head3",      drp_data[124:93], 32'h3);
        cyc();
        chk("fp_empty",      drp_valid, 1'b0);

        // User packing and stream type tag
        reset = 1'b1; ready = 1'b0; bvalid = 1'b0;
        cyc();
        reset = 1'b0; bid = 32'hA; bresp = 2'b01; buser = 64'hDEAD_BEEF_0000_0001; bvalid = 1'b1;
        #1;
        chk("usr_m_bresp",   usr_m_bresp, 2'b01);
        chk("usr_m_bid",     drp_m_bid, 32'hA);
        chk("usr_m_buser",   blk_m_buser, 64'hDEAD_BEEF_0000_0001);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("usr_valid",     usr_valid, 1'b1);
        chk("usr_beat",      usr_data, BEAT_USER);
        cyc();
        chk("usr_held",      usr_data, BEAT_USER);
        chk("usr_occ1",      usr_occ, 3'd1);
        chk("usr_drops",     usr_drops, 16'd0);

        // Reset mid-queue flushes three entries without emitting any
        bid = 32'hB; bvalid = 1'b1;
        cyc();
        bid = 32'hC;
        cyc();
        bvalid = 1'b0;
        #1;
        chk("flush_occ3",    usr_occ, 3'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0; ready = 1'b1;
        #1;
        chk("flush_occ0",    usr_occ, 3'd0);
        chk("flush_valid",   usr_valid, 1'b0);
        chk("flush_inprog",  usr_inprog, 1'b0);
        cyc();
        chk("flush_valid2",  usr_valid, 1'b0);
        chk("flush_last",    usr_last, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_to_stream_b_fifo.md
# axi_to_stream_b_fifo

Snoops AXI4 write-response (B) handshakes between an AXI slave-side and master-side port, forwards them unchanged, and queues a copy of each response in an internal FIFO. Queued responses are emitted one beat each on the shared stream-output interface used by the sibling channel snoopers, so AXI B traffic no longer stalls while the stream arbiter is busy. A mode parameter selects whether a full FIFO back-pressures the AXI channel or drops and counts the copy.

## Interface
- DATA_WIDTH, 128, stream beat width
- ID_WIDTH, 32, AXI bid width
- USER_WIDTH, 64, AXI buser width
- STREAM_TYPE, 3'b0, type tag placed in beat MSBs
- STREAM_TYPE_WIDTH, 3, width of STREAM_TYPE
- FIFO_DEPTH, 4, queued responses; power of two, ≥2
- INCLUDE_USER, 0, 1 = pack buser into the beat
- BLOCK_ON_FULL, 1, 1 = gate the AXI handshake while full; 0 = never gate, drop the copy while full

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ready  in  1  stream arbiter accepts the beat this cycle
- valid  out  1  head-of-FIFO beat available
- in_progress  out  1  a beat is being transferred this cycle
- last  out  1  final beat of the packet
- data  out  DATA_WIDTH  formatted beat
- occupancy  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_count  out  16  saturating count of dropped copies
- AXIS_bid / AXIS_bresp / AXIS_buser  in  ID_WIDTH / 2 / USER_WIDTH  slave-side response
- AXIS_bvalid  in  1;  AXIS_bready  out  1
- AXIM_bid / AXIM_bresp / AXIM_buser  out  ID_WIDTH / 2 / USER_WIDTH  master-side response
- AXIM_bvalid  out  1;  AXIM_bready  in  1

## Operation
- The id, resp and user fields pass through combinationally, slave side to master side.
- Gate signal g is defined as `reset || !(BLOCK_ON_FULL && full)`.
  - AXIM_bvalid = AXIS_bvalid && g
  - AXIS_bready = AXIM_bready && g
- While reset is high the AXI channel is ungated and nothing is captured.
- Capture: cap = !reset && AXIS_bvalid && AXIM_bready && g.
  - On cap with the FIFO not full, push {bid, bresp, buser}.
  - On cap with the FIFO full, drop the copy (only possible when BLOCK_ON_FULL=0). drop_count increments and saturates at 16'hFFFF.
- Stream side:
  - valid = !empty
  - Pop when valid && ready.
  - in_progress = valid && ready.
  - last = valid && ready, because every packet is a single beat.
- Beat format, MSB to LSB:
  - STREAM_TYPE
  - bid
  - zero pad
  - buser, only if INCLUDE_USER
  - bresp
- Width rule: DATA_WIDTH ≥ STREAM_TYPE_WIDTH + ID_WIDTH + 2 (+ USER_WIDTH when INCLUDE_USER). Violating it is an elaboration error (`$error`).
- FIFO implementation:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap naturally.
  - occupancy is a separate counter.
  - full = (occupancy == FIFO_DEPTH); empty = (occupancy == 0).
- Simultaneous push and pop:
  - Not full and not empty: both occur and occupancy is unchanged.
  - Empty: push occurs; pop cannot, because valid is low.
  - Full: full is evaluated on the current occupancy, so a same-cycle pop does not free a slot for that cycle's capture. With BLOCK_ON_FULL=1 the AXI side is gated that cycle; with BLOCK_ON_FULL=0 the copy is dropped.

## Timing
- Reset values, applied on the first rising edge with reset high:
  - occupancy = 0, pointers = 0, drop_count = 0
  - valid / in_progress / last = 0 from the following cycle
- Reset mid-operation flushes all queued beats; none are emitted.
- Capture-to-stream latency is 1 cycle: a response handshaken at edge N gives valid high after edge N.
- data is stable and held while valid && !ready.
- A beat is consumed only on a cycle where valid && ready.
- Throughput is one capture and one emit per cycle.
- AXI gating depends only on registered state plus inputs. With BLOCK_ON_FULL=1 it is combinational from the full flag, so there is no combinational path from ready to AXIS_bready.
- data is driven from the FIFO head, and is combinational only through the read pointer.

## Test plan
- **Reset:** assert reset for 2 cycles while AXIS_bvalid=1 and AXIM_bready=1 -> the AXI handshake passes ungated, valid=0, occupancy=0, drop_count=0.
- **Single response:** bid=32'h5, bresp=2'b10, ready=1 -> valid is high 1 cycle after the handshake, with data = {3'b000, 32'h5, 0…, 2'b10} and last=in_progress=1 for 1 cycle.
- **Back-pressure:** BLOCK_ON_FULL=1, DEPTH=4, ready=0, 6 back-to-back responses -> 4 captured, then AXIS_bready=AXIM_bvalid=0. Raising ready gives beats in order with ids 0..3, and the remaining 2 then complete.
- **Drop mode:** BLOCK_ON_FULL=0, DEPTH=4, ready=0, 6 responses -> all 6 AXI handshakes complete, occupancy=4, drop_count=2.
- **Full with simultaneous pop:** FIFO full, ready=1, a new response arrives:
  - BLOCK_ON_FULL=1: AXI is gated that cycle and the response is captured the next cycle.
  - BLOCK_ON_FULL=0: the copy is dropped and drop_count increments.
- **INCLUDE_USER=1:** buser=64'hDEAD_BEEF_0000_0001 -> the beat has buser immediately above bresp. Also hold reset mid-queue with 3 entries -> the queue is flushed and no beats are emitted.
